// File: rtl/score_digit_sequencer.sv
// Score display sequencer: double-dabble BCD conversion committed at frame start, plus slot rendering.
// Optional build macro LEADING_ZERO_BLANK_EN hides leading-zero slots (the units slot always draws).
module score_digit_sequencer #(
  parameter int         DIGITS    = 4,
  parameter logic [10:0] TOPLEFT_X = 11'd32,
  parameter logic [10:0] TOPLEFT_Y = 11'd16,
  parameter int         DIGIT_W   = 16,
  parameter int         DIGIT_H   = 32
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [13:0] value,
  input  logic        valueValid,
  output logic        valueReady,
  output logic        busy,
  output logic [3:0]  digit,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle
);

  localparam int         LOG2W = $clog2(DIGIT_W);
  localparam logic [11:0] X_END = {1'b0, TOPLEFT_X} + 12'(DIGITS * DIGIT_W);
  localparam logic [11:0] Y_END = {1'b0, TOPLEFT_Y} + 12'(DIGIT_H);

  typedef enum logic [1:0] {IDLE, CONVERT, PENDING} state_t;

  state_t      state_q, state_d;
  logic [13:0] val_q, val_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] adj;

  function automatic logic [13:0] clamp_score(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  assign valueReady = resetN && (state_q == IDLE);
  assign busy       = resetN && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    adj     = add3(bcd_q);
    case (state_q)
      IDLE: if (valueValid) begin
        val_d   = clamp_score(value);
        bcd_d   = 16'd0;
        cnt_d   = 4'd0;
        state_d = CONVERT;
      end
      CONVERT: begin
        bcd_d = {adj[14:0], val_q[13]};
        val_d = {val_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = PENDING;
      end
      PENDING: if (startOfFrame) begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and the display register clear on reset; the conversion datapath does not.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      disp_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
    val_q <= val_d;
    bcd_q <= bcd_d;
  end

  logic [10:0] rel_x, rel_y;
  logic        in_slot, blank, draw;
  logic [1:0]  slot, pos;
  logic [3:0]  nib;

  always_comb begin
    rel_x   = pixelX - TOPLEFT_X;
    rel_y   = pixelY - TOPLEFT_Y;
    in_slot = (pixelX >= TOPLEFT_X) && ({1'b0, pixelX} < X_END) &&
              (pixelY >= TOPLEFT_Y) && ({1'b0, pixelY} < Y_END);
    slot    = 2'(rel_x >> LOG2W);
    pos     = 2'(DIGITS - 1) - slot;
    nib     = disp_q[{pos, 2'b00} +: 4];
    blank   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic       run;
      logic [3:0] lz;
      run = 1'b1;
      lz  = 4'b0;
      for (int p = 3; p >= 0; p--) begin
        if (p <= DIGITS - 1) begin
          run   = run && (disp_q[p*4 +: 4] == 4'd0);
          lz[p] = run;
        end
      end
      blank = (pos != 2'd0) && lz[pos];
    end
`endif
    draw = in_slot && !blank;
  end

  // Registered pixel outputs: one clock behind pixelX/pixelY.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      InsideRectangle <= 1'b0;
      digit           <= 4'd0;
      offsetX         <= 11'd0;
      offsetY         <= 11'd0;
    end else begin
      InsideRectangle <= draw;
      digit           <= draw ? nib : 4'd0;
      offsetX         <= draw ? (rel_x & 11'(DIGIT_W - 1)) : 11'd0;
      offsetY         <= draw ? rel_y : 11'd0;
    end
  end

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Directed bench for score_digit_sequencer with default parameters (either macro setting).
module tb_score_digit_sequencer;
  logic        clk = 1'b0;
  logic        resetN, startOfFrame, valueValid;
  logic [10:0] pixelX, pixelY;
  logic [13:0] value;
  logic        valueReady, busy, InsideRectangle;
  logic [3:0]  digit;
  logic [10:0] offsetX, offsetY;
  int tests = 0;
  int fails = 0;

  score_digit_sequencer dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .value(value), .valueValid(valueValid),
    .valueReady(valueReady), .busy(busy), .digit(digit),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_slot(input int s, output logic [3:0] d, output logic ins);
    pixelX = 11'(32 + s * 16 + 2);
    pixelY = 11'd17;
    step();
    d   = digit;
    ins = InsideRectangle;
  endtask

  task automatic offer(input logic [13:0] v);
    int n = 0;
    while (!valueReady && n < 50) begin step(); n++; end
    tests++;
    if (!valueReady) begin fails++; $display("FAIL offer_ready got %0d want 1", valueReady); end
    value = v; valueValid = 1'b1;
    step();
    valueValid = 1'b0;
  endtask

  task automatic commit();
    int n = 0;
    while (n < 14) begin step(); n++; end
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  task automatic check_display(input string name, input logic [15:0] bcd);
    logic [3:0] d; logic ins;
    for (int s = 0; s < 4; s++) begin
      read_slot(s, d, ins);
      tests++;
      if (d !== bcd[(3 - s) * 4 +: 4]) begin
        fails++;
        $display("FAIL %s slot%0d digit got %0d want %0d", name, s, d, bcd[(3 - s) * 4 +: 4]);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] d; logic ins;
    resetN = 1'b0; startOfFrame = 1'b0; valueValid = 1'b0; value = 14'd0;
    pixelX = 11'd40; pixelY = 11'd20;
    step(); step();
    tests++;
    if ({valueReady, busy, InsideRectangle} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl got %b want 000", {valueReady, busy, InsideRectangle});
    end
    tests++;
    if ({digit, offsetX, offsetY} !== 26'd0) begin
      fails++; $display("FAIL reset_data got %0d/%0d/%0d want 0/0/0", digit, offsetX, offsetY);
    end
    resetN = 1'b1;
    #1;
    tests++;
    if (valueReady !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_release ready=%b busy=%b want 1/0", valueReady, busy);
    end
    read_slot(3, d, ins);
    tests++;
    if (ins !== 1'b1 || d !== 4'd0) begin
      fails++; $display("FAIL reset_display ins=%b digit=%0d want 1/0", ins, d);
    end
  endtask

  task automatic test_convert_1234();
    int busy_cnt = 0;
    offer(14'd1234);
    pixelX = 11'd82; pixelY = 11'd17;
    if (busy) busy_cnt++;
    for (int i = 0; i < 19; i++) begin
      step();
      if (busy) busy_cnt++;
      tests++;
      if (digit !== 4'd0) begin fails++; $display("FAIL pre_commit_digit cyc%0d got %0d want 0", i, digit); end
    end
    tests++;
    if (busy_cnt !== 20) begin fails++; $display("FAIL busy_cycles got %0d want 20", busy_cnt); end
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    tests++;
    if (busy !== 1'b0 || valueReady !== 1'b1) begin
      fails++; $display("FAIL post_commit busy=%b ready=%b want 0/1", busy, valueReady);
    end
    check_display("disp1234", 16'h1234);
  endtask

  task automatic test_sof_last_convert();
    offer(14'd5678);
    for (int i = 0; i < 13; i++) step();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL sof_last_convert busy got %b want 1", busy); end
    check_display("no_early_commit", 16'h1234);
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    check_display("disp5678", 16'h5678);
  endtask

  task automatic test_clamp();
    offer(14'd16383);
    commit();
    check_display("clamp", 16'h9999);
  endtask

  task automatic test_busy_ignore();
    offer(14'd2468);
    value = 14'd55; valueValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (valueReady !== 1'b0) begin fails++; $display("FAIL busy_ready cyc%0d got %b want 0", i, valueReady); end
      step();
    end
    valueValid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_ignore_idle busy got %b want 0", busy); end
    check_display("disp2468", 16'h2468);
  endtask

  task automatic test_geometry();
    pixelX = 11'd51; pixelY = 11'd21;
    step();
    tests++;
    if ({InsideRectangle, offsetX, offsetY, digit} !== {1'b1, 11'd3, 11'd5, 4'd4}) begin
      fails++; $display("FAIL geom_in ins=%b ox=%0d oy=%0d d=%0d want 1/3/5/4", InsideRectangle, offsetX, offsetY, digit);
    end
    pixelX = 11'd31;
    step();
    tests++;
    if ({InsideRectangle, offsetX, offsetY, digit} !== 27'd0) begin
      fails++; $display("FAIL geom_left ins=%b ox=%0d oy=%0d d=%0d want all 0", InsideRectangle, offsetX, offsetY, digit);
    end
    pixelX = 11'd95; pixelY = 11'd47;
    step();
    tests++;
    if ({InsideRectangle, offsetX, offsetY, digit} !== {1'b1, 11'd15, 11'd31, 4'd8}) begin
      fails++; $display("FAIL geom_corner ins=%b ox=%0d oy=%0d d=%0d want 1/15/31/8", InsideRectangle, offsetX, offsetY, digit);
    end
    pixelX = 11'd96;
    step();
    tests++;
    if (InsideRectangle !== 1'b0) begin fails++; $display("FAIL geom_right ins got %b want 0", InsideRectangle); end
    pixelX = 11'd40; pixelY = 11'd48;
    step();
    tests++;
    if (InsideRectangle !== 1'b0) begin fails++; $display("FAIL geom_below ins got %b want 0", InsideRectangle); end
    pixelY = 11'd15;
    step();
    tests++;
    if (InsideRectangle !== 1'b0) begin fails++; $display("FAIL geom_above ins got %b want 0", InsideRectangle); end
  endtask

  task automatic test_reset_pending();
    offer(14'd4321);
    for (int i = 0; i < 15; i++) step();
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || valueReady !== 1'b1) begin
      fails++; $display("FAIL abort_state busy=%b ready=%b want 0/1", busy, valueReady);
    end
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    check_display("abort", 16'h0000);
  endtask

  task automatic test_leading_zero();
    logic [3:0] d; logic ins;
    logic [3:0] want_ins;
`ifdef LEADING_ZERO_BLANK_EN
    want_ins = 4'b1000;
`else
    want_ins = 4'b1111;
`endif
    offer(14'd7);
    commit();
    for (int s = 0; s < 4; s++) begin
      read_slot(s, d, ins);
      tests++;
      if (ins !== want_ins[3 - s]) begin
        fails++; $display("FAIL lz_ins slot%0d got %b want %b", s, ins, want_ins[3 - s]);
      end
      if (want_ins[3 - s]) begin
        tests++;
        if (d !== ((s == 3) ? 4'd7 : 4'd0)) begin
          fails++; $display("FAIL lz_digit slot%0d got %0d want %0d", s, d, (s == 3) ? 7 : 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_sof_last_convert();
    test_clamp();
    test_busy_ignore();
    test_geometry();
    test_reset_pending();
    test_leading_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/score_digit_sequencer.md
SCORE_DIGIT_SEQUENCER -- requirements
Module: score_digit_sequencer

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of decimal digit slots (1..4).
REQ-002 SHALL have parameter TOPLEFT_X, default 11'd32, screen X of the leftmost slot.
REQ-003 SHALL have parameter TOPLEFT_Y, default 11'd16, screen Y of the slot row.
REQ-004 SHALL have parameter DIGIT_W, default 16, slot width in pixels; power of two.
REQ-005 SHALL have parameter DIGIT_H, default 32, slot height in pixels.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-007 SHALL have port resetN, input, 1, synchronous active-low reset.
REQ-008 SHALL have port startOfFrame, input, 1, one-cycle pulse at the first pixel of each frame.
REQ-009 SHALL have port pixelX, input, 11, current pixel column.
REQ-010 SHALL have port pixelY, input, 11, current pixel row.
REQ-011 SHALL have port value, input, 14, binary score to display.
REQ-012 SHALL have port valueValid, input, 1, value offered this cycle.
REQ-013 SHALL have port valueReady, output, 1, block accepts value this cycle.
REQ-014 SHALL have port busy, output, 1, a conversion or a pending commit is in progress.
REQ-015 SHALL have port digit, output, 4, BCD digit for the current pixel's slot.
REQ-016 SHALL have port offsetX, output, 11, pixel X offset within the slot (0..DIGIT_W-1).
REQ-017 SHALL have port offsetY, output, 11, pixel Y offset within the slot (0..DIGIT_H-1).
REQ-018 SHALL have port InsideRectangle, output, 1, the pixel lies in a drawn slot.

Function
REQ-019 SHALL implement FSM IDLE -> CONVERT -> PENDING -> IDLE.
REQ-020 SHALL drive valueReady=1 only in IDLE; accept when valueValid && valueReady, latch value, enter CONVERT.
REQ-021 SHALL clamp an accepted value above 9999 to 9999 before conversion.
REQ-022 SHALL convert with shift-add-3 (double-dabble), one bit per cycle, exactly 14 CONVERT cycles, then enter PENDING.
REQ-023 SHALL, in PENDING, copy the converted BCD digits into the display register on a cycle with startOfFrame=1 and enter IDLE; the display register SHALL change at no other time.
REQ-024 SHALL ignore startOfFrame in IDLE and CONVERT; a pulse on the last CONVERT cycle SHALL NOT commit.
REQ-025 SHALL drive busy=1 in CONVERT and PENDING; valueValid during busy SHALL be ignored (not accepted).
REQ-026 SHALL map slot index s = (pixelX - TOPLEFT_X) >> log2(DIGIT_W); s=0 is the most significant displayed digit.
REQ-027 SHALL treat a pixel as in a slot iff TOPLEFT_X <= pixelX < TOPLEFT_X+DIGITS*DIGIT_W and TOPLEFT_Y <= pixelY < TOPLEFT_Y+DIGIT_H; no wrap-around for pixels left of or above the origin.
REQ-028 SHALL register digit, offsetX, offsetY and InsideRectangle: one clk latency from pixelX/pixelY; outside any slot, InsideRectangle=0 and offsetX, offsetY, digit=0.
REQ-029 SHALL place the least significant DIGITS decimal digits of the displayed value in the slots.

Reset
REQ-030 SHALL, on resetN=0 at a clk edge, enter IDLE, clear the display register to 0, and drive valueReady=0, busy=0, InsideRectangle=0, digit=0, offsetX=0, offsetY=0 while reset is held.
REQ-031 SHALL abandon a conversion or pending commit on reset mid-operation; the aborted value SHALL never be displayed.
REQ-032 SHALL raise valueReady on the first cycle after resetN returns to 1.

Configuration
REQ-033 SHALL, with LEADING_ZERO_BLANK_EN defined, force InsideRectangle=0 for every leading-zero slot other than the least significant one (value 0 shows a single "0").
REQ-034 SHALL, without LEADING_ZERO_BLANK_EN, draw every slot including leading zeros.

Verification
REQ-035 SHALL verify: value=1234 accepted, startOfFrame 20 cycles later -> busy for 14+wait cycles, slots read 1,2,3,4 from the frame after the pulse.
REQ-036 SHALL verify: value=16383 -> display 9999.
REQ-037 SHALL verify: valueValid with value=55 during CONVERT -> valueReady=0, not accepted, display shows the first value only.
REQ-038 SHALL verify: pixelX=TOPLEFT_X+DIGIT_W+3, pixelY=TOPLEFT_Y+5 -> next cycle InsideRectangle=1, offsetX=3, offsetY=5, digit=slot-1 digit; pixelX=TOPLEFT_X-1 -> InsideRectangle=0.
REQ-039 SHALL verify: resetN=0 in PENDING for value 4321 -> IDLE, display 0, later startOfFrame does not show 4321.
REQ-040 SHALL verify: value=7 with LEADING_ZERO_BLANK_EN -> slots 0-2 InsideRectangle=0, slot 3 draws 7; without the macro -> 0,0,0,7 drawn.
